// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: shares one single-port memory between instruction fetch
// (imem) and load/store (dmem). One transaction is outstanding at a time and
// simultaneous requests are served round-robin. The winning request is issued
// to memory in the arbitration cycle itself, then held from captured
// registers until the memory grants it.
module yarp_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // instruction fetch port
  input  logic                imem_req_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  output logic                imem_gnt_o,
  output logic                imem_rvalid_o,
  output logic [DATA_W-1:0]   imem_rdata_o,
  // load/store port
  input  logic                dmem_req_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  input  logic                dmem_we_i,
  input  logic [DATA_W/8-1:0] dmem_be_i,
  input  logic [DATA_W-1:0]   dmem_wdata_i,
  output logic                dmem_gnt_o,
  output logic                dmem_rvalid_o,
  output logic [DATA_W-1:0]   dmem_rdata_o,
  // shared memory port
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {ARB, LOCKED, WAIT_RSP} state_t;
  typedef enum logic {OWN_IMEM = 1'b0, OWN_DMEM = 1'b1} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_q, last_d;
  owner_t            winner;
  logic              any_req;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  assign any_req = imem_req_i | dmem_req_i;

  // Round-robin pick: a sole requester wins; a tie goes to whoever was not served last.
  always_comb begin
    winner = OWN_IMEM;
    if (imem_req_i && dmem_req_i) begin
      if (last_q == OWN_IMEM) winner = OWN_DMEM;
    end else if (dmem_req_i) begin
      winner = OWN_DMEM;
    end
  end

  // Next-state, capture and output decode for the ARB/LOCKED/WAIT_RSP handshake.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    addr_d        = addr_q;
    we_d          = we_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    mem_we_o      = 1'b0;
    mem_be_o      = '0;
    mem_wdata_o   = '0;
    imem_gnt_o    = 1'b0;
    dmem_gnt_o    = 1'b0;
    imem_rvalid_o = 1'b0;
    dmem_rvalid_o = 1'b0;
    imem_rdata_o  = '0;
    dmem_rdata_o  = '0;
    // NOTE: outputs are gated by reset_n so they read 0 the moment reset asserts,
    // even though requests may still be driving the combinational issue path.
    if (reset_n) begin
      imem_rdata_o = mem_rdata_i;
      dmem_rdata_o = mem_rdata_i;
      unique case (state_q)
        ARB: begin
          if (any_req) begin
            mem_req_o = 1'b1;
            if (winner == OWN_DMEM) begin
              mem_addr_o  = dmem_addr_i;
              mem_we_o    = dmem_we_i;
              mem_be_o    = dmem_be_i;
              mem_wdata_o = dmem_wdata_i;
            end else begin
              mem_addr_o  = imem_addr_i;
              mem_be_o    = '1;
            end
            addr_d  = mem_addr_o;
            we_d    = mem_we_o;
            be_d    = mem_be_o;
            wdata_d = mem_wdata_o;
            owner_d = winner;
            if (mem_gnt_i) begin
              imem_gnt_o = (winner == OWN_IMEM);
              dmem_gnt_o = (winner == OWN_DMEM);
              state_d    = WAIT_RSP;
            end else begin
              state_d    = LOCKED;
            end
          end
        end
        LOCKED: begin
          mem_req_o   = 1'b1;
          mem_addr_o  = addr_q;
          mem_we_o    = we_q;
          mem_be_o    = be_q;
          mem_wdata_o = wdata_q;
          if (mem_gnt_i) begin
            imem_gnt_o = (owner_q == OWN_IMEM);
            dmem_gnt_o = (owner_q == OWN_DMEM);
            state_d    = WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            imem_rvalid_o = (owner_q == OWN_IMEM);
            dmem_rvalid_o = (owner_q == OWN_DMEM);
            last_d        = owner_q;
            state_d       = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // State, ownership history and captured request fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      owner_q <= OWN_IMEM;
      last_q  <= OWN_DMEM;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// Randomized scoreboard bench for yarp_mem_arbiter. A transaction-level model
// (pending requesters, one transaction in flight, round-robin on ties) predicts
// each issue and pushes it into a queue; a negedge monitor pops and compares
// whenever the DUT presents a grant or a response.
module tb_yarp_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_IM   = 2'b01;  // matches {dmem_x, imem_x} bit order
  localparam logic [1:0] W_DM   = 2'b10;

  typedef struct packed {
    logic [1:0]        who;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              imem_req_i, imem_gnt_o, imem_rvalid_o;
  logic [ADDR_W-1:0] imem_addr_i;
  logic [DATA_W-1:0] imem_rdata_o;
  logic              dmem_req_i, dmem_we_i, dmem_gnt_o, dmem_rvalid_o;
  logic [ADDR_W-1:0] dmem_addr_i;
  logic [BE_W-1:0]   dmem_be_i;
  logic [DATA_W-1:0] dmem_wdata_i, dmem_rdata_o;
  logic              mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o, mem_rdata_i;

  yarp_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i), .imem_gnt_o(imem_gnt_o),
    .imem_rvalid_o(imem_rvalid_o), .imem_rdata_o(imem_rdata_o),
    .dmem_req_i(dmem_req_i), .dmem_addr_i(dmem_addr_i), .dmem_we_i(dmem_we_i),
    .dmem_be_i(dmem_be_i), .dmem_wdata_i(dmem_wdata_i), .dmem_gnt_o(dmem_gnt_o),
    .dmem_rvalid_o(dmem_rvalid_o), .dmem_rdata_o(dmem_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus knobs (percent)
  int p_req, p_gnt, p_mut, p_spur;

  // transaction-level model
  logic       m_active, m_granted;
  int         m_delay;
  logic [1:0] m_last;
  txn_t       m_txn;
  logic       e_req;
  logic [1:0] e_gnt, e_rv;

  txn_t issue_q[$];
  txn_t rsp_q[$];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory macro read data is a fixed function of the address.
  function automatic logic [DATA_W-1:0] resp_data(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_granted = 1'b0;
    m_delay   = 0;
    m_last    = W_DM;
    e_req     = 1'b0;
    e_gnt     = W_NONE;
    e_rv      = W_NONE;
    issue_q.delete();
    rsp_q.delete();
  endtask

  // One cycle of stimulus plus model update; called just after a posedge.
  task automatic do_cycle();
    // requesters release after their grant, then may re-request at random
    if (e_gnt == W_IM) imem_req_i = 1'b0;
    if (e_gnt == W_DM) dmem_req_i = 1'b0;
    if (!imem_req_i) begin
      if ($urandom_range(99) < p_req) begin
        imem_req_i  = 1'b1;
        imem_addr_i = $urandom & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(99) < p_mut) begin
      imem_addr_i = imem_addr_i + 32'd4;
    end
    if (!dmem_req_i) begin
      if ($urandom_range(99) < p_req) begin
        dmem_req_i   = 1'b1;
        dmem_addr_i  = $urandom;
        dmem_we_i    = 1'($urandom_range(1));
        dmem_be_i    = 4'($urandom_range(15));
        dmem_wdata_i = $urandom;
      end
    end else if ($urandom_range(99) < p_mut) begin
      dmem_addr_i  = $urandom;
      dmem_wdata_i = $urandom;
    end
    // memory agent: random grants (also while idle), response after 1..3 cycles,
    // occasional spurious response when nothing is outstanding
    mem_gnt_i = ($urandom_range(99) < p_gnt);
    if (m_granted) mem_rvalid_i = (m_delay == 0);
    else           mem_rvalid_i = ($urandom_range(99) < p_spur);
    mem_rdata_i = m_granted ? resp_data(m_txn.addr) : $urandom;
    // model
    e_req = 1'b0;
    e_gnt = W_NONE;
    e_rv  = W_NONE;
    if (!m_active && (imem_req_i || dmem_req_i)) begin
      if (imem_req_i && (!dmem_req_i || m_last == W_DM))
        m_txn = '{who: W_IM, addr: imem_addr_i, we: 1'b0, be: '1, wdata: '0};
      else
        m_txn = '{who: W_DM, addr: dmem_addr_i, we: dmem_we_i, be: dmem_be_i, wdata: dmem_wdata_i};
      m_active  = 1'b1;
      m_granted = 1'b0;
      issue_q.push_back(m_txn);
    end
    if (m_active && !m_granted) begin
      e_req = 1'b1;
      if (mem_gnt_i) begin
        e_gnt     = m_txn.who;
        m_granted = 1'b1;
        m_delay   = $urandom_range(2);
      end
    end else if (m_granted && mem_rvalid_i) begin
      e_rv      = m_txn.who;
      m_last    = m_txn.who;
      m_active  = 1'b0;
      m_granted = 1'b0;
    end else if (m_granted) begin
      m_delay--;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    do_cycle();
  endtask

  task automatic run_phase(input int n, input int rq, input int gn, input int mu, input int sp);
    p_req = rq; p_gnt = gn; p_mut = mu; p_spur = sp;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
                 imem_gnt_o, imem_rvalid_o, dmem_gnt_o, dmem_rvalid_o}, '0);
    check({name, "_rdata"}, {imem_rdata_o, dmem_rdata_o}, '0);
  endtask

  // Monitor: compares per-cycle handshakes and pops the scoreboard on grants/responses.
  always @(negedge clk) begin
    txn_t t;
    if (!reset_n) begin
      check_all_zero("reset_outputs");
    end else begin
      check("mem_req", mem_req_o, e_req);
      check("gnt_vec", {dmem_gnt_o, imem_gnt_o}, e_gnt);
      check("rvalid_vec", {dmem_rvalid_o, imem_rvalid_o}, e_rv);
      if (mem_req_o) begin
        if (issue_q.size() == 0) check("issue_unexpected", 1'b1, 1'b0);
        else check("issue_fields", {mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o},
                   {issue_q[0].addr, issue_q[0].we, issue_q[0].be, issue_q[0].wdata});
      end
      if (imem_gnt_o || dmem_gnt_o) begin
        if (issue_q.size() == 0) begin
          check("gnt_unexpected", 1'b1, 1'b0);
        end else begin
          t = issue_q.pop_front();
          check("gnt_owner", {dmem_gnt_o, imem_gnt_o}, t.who);
          rsp_q.push_back(t);
        end
      end
      if (imem_rvalid_o || dmem_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          t = rsp_q.pop_front();
          check("rsp_owner", {dmem_rvalid_o, imem_rvalid_o}, t.who);
          check("rsp_rdata", (t.who == W_IM) ? imem_rdata_o : dmem_rdata_o, resp_data(t.addr));
        end
      end
    end
  end

  initial begin
    reset_n      = 1'b0;
    imem_req_i   = 1'b0;
    imem_addr_i  = '0;
    dmem_req_i   = 1'b0;
    dmem_addr_i  = '0;
    dmem_we_i    = 1'b0;
    dmem_be_i    = '0;
    dmem_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // continuous ties with immediate grants: strict IMEM/DMEM alternation
    run_phase(40, 100, 100, 0, 0);
    // mixed traffic with wait states, field churn while locked, spurious responses
    run_phase(500, 60, 50, 25, 10);
    run_phase(500, 25, 30, 40, 20);

    // reset while a response is outstanding
    p_req = 100; p_gnt = 100; p_mut = 0; p_spur = 0;
    for (int k = 0; k < 20 && !m_granted; k++) cycle();
    check("reach_wait_rsp", m_granted, 1'b1);
    @(posedge clk);
    #1;
    reset_n      = 1'b0;
    mem_rvalid_i = 1'b1;
    imem_req_i   = 1'b1;
    dmem_req_i   = 1'b1;
    #1;
    check_all_zero("reset_immediate");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    do_cycle();
    #1;
    check("tie_after_reset", {dmem_gnt_o, imem_gnt_o}, W_IM);

    // drain outstanding work, bounded
    p_req = 0;
    for (int k = 0; k < 40 && (m_active || imem_req_i || dmem_req_i); k++) cycle();
    cycle();
    @(negedge clk);
    #1;
    check("drained", {m_active, 8'(issue_q.size()), 8'(rsp_q.size())}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yarp_mem_arbiter.md
Name: yarp_mem_arbiter

Overview:
- Shares one single-port memory between instruction fetch (imem) and load/store (dmem) requesters in the yarp core.
- Uses a req/gnt/rvalid handshake on every port, with exactly one transaction outstanding at a time.
- Round-robin priority on simultaneous requests, so neither requester starves.
- Sits between the fetch/LSU stages and the shared memory macro or bus.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- imem_req_i  in  1  fetch request; held with addr until imem_gnt_o
- imem_addr_i  in  ADDR_W  fetch address
- imem_gnt_o  out  1  fetch request accepted by memory
- imem_rvalid_o  out  1  fetch data valid
- imem_rdata_o  out  DATA_W  fetch data
- dmem_req_i  in  1  load/store request; held with fields until dmem_gnt_o
- dmem_addr_i  in  ADDR_W  data address
- dmem_we_i  in  1  1=store, 0=load
- dmem_be_i  in  DATA_W/8  byte enables
- dmem_wdata_i  in  DATA_W  store data
- dmem_gnt_o  out  1  data request accepted
- dmem_rvalid_o  out  1  load data / store ack valid
- dmem_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  request to memory
- mem_addr_o  out  ADDR_W  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid; one per granted request, stores included
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- States: ARB, LOCKED, WAIT_RSP. Reset state is ARB.
- Registers: owner (IMEM/DMEM), last_served, captured request fields.
- Reset values:
  - All outputs 0.
  - last_served = DMEM, so the first tie goes to IMEM (boot fetch).
  - Captured fields 0.
- ARB, no requests: mem_req_o=0.
- ARB, one or both requests:
  - Winner = sole requester; on a tie, the requester that is not last_served.
  - mem_req_o=1 and mem_* driven combinationally from the winner's inputs in the same cycle (zero-cycle issue).
  - Winner's fields captured into registers; owner=winner.
  - If mem_gnt_i=1: owner's gnt_o=1 this cycle, go to WAIT_RSP.
  - Else: go to LOCKED.
- IMEM-won requests drive mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
- LOCKED:
  - mem_req_o=1, mem_* driven from the captured registers.
  - Requester deasserting req or changing fields is ignored.
  - The other requester is not granted.
  - On mem_gnt_i: owner's gnt_o=1, go to WAIT_RSP.
- WAIT_RSP:
  - mem_req_o=0; no gnt_o asserted to anyone.
  - On mem_rvalid_i: owner's rvalid_o=1; last_served=owner; go to ARB.
  - New arbitration happens in the following cycle, not the rvalid cycle.
- imem_rdata_o and dmem_rdata_o = mem_rdata_i combinationally. Only the owner's rvalid_o qualifies the data.
- gnt_o and rvalid_o are never asserted to the non-owner.
- At most one of imem_gnt_o/dmem_gnt_o per cycle; same for rvalid_o.
- mem_rvalid_i in ARB or LOCKED is a protocol violation: ignored, no state change, no rvalid_o.
- mem_gnt_i while mem_req_o=0 is ignored.
- Minimum transaction time is 2 cycles (gnt in issue cycle, rvalid next cycle). Peak throughput is one transaction per 2 cycles.
- Reset asserted mid-transaction: immediate return to ARB, all outputs 0, last_served=DMEM. The in-flight response is discarded.

Test Plan:
- Fetch alone, memory gnt same cycle:
  - imem_req=1, addr=0x100; memory gnt in cycle 0, rvalid cycle 1, rdata=0x00000013.
  - Required: imem_gnt_o in cycle 0; imem_rvalid_o in cycle 1 with 0x00000013; dmem outputs stay 0.
- Store alone, with wait states:
  - dmem_req=1, we=1, be=0x3, wdata=0xDEADBEEF, addr=0x2000; gnt delayed 2 cycles.
  - Required: mem_req_o held 3 cycles with unchanged fields; dmem_gnt_o pulses once; dmem_rvalid_o on mem ack.
- Simultaneous requests from reset, repeated 4 transactions:
  - Both requesters assert continuously.
  - Required: grant order IMEM, DMEM, IMEM, DMEM.
- Field stability in LOCKED:
  - Requester changes addr 0x100 to 0x104 while gnt is withheld.
  - Required: mem_addr_o stays 0x100 until gnt.
- Spurious memory response:
  - mem_rvalid_i=1 while in ARB.
  - Required: no rvalid_o asserted, state unchanged.
- Reset mid-operation:
  - reset_n=0 during WAIT_RSP.
  - Required: all outputs 0 immediately; after release, a tie goes to IMEM first.
